// File: rtl/dezigzag_dequant.sv
// Zigzag-order coefficient stream -> dequantized, saturated, row-major 8x8 block for the IDCT.
// Double-buffered fill/emit; define DEZIGZAG_DC_PRED_EN to treat the DC term as a predicted difference.
module dezigzag_dequant #(
    parameter int OUT_GAP = 40,
    parameter int CW      = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          coef_valid,
    output logic          coef_ready,
    input  logic [5:0]    coef_run,
    input  logic [CW-1:0] coef_value,
    input  logic          coef_eob,
    input  logic          qt_wr_en,
    input  logic [5:0]    qt_wr_addr,
    input  logic [7:0]    qt_wr_data,
    input  logic          dc_pred_clr,
    output logic          blk_valid,
    output logic [511:0]  blk_data,
    output logic          err_overrun
);

    typedef enum logic [1:0] {
        BUF_EMPTY,
        BUF_FILLING,
        BUF_FULL,
        BUF_EMITTED
    } buf_state_t;

`ifdef DEZIGZAG_DC_PRED_EN
    localparam int VW = CW + 1;
`else
    localparam int VW = CW;
`endif
    localparam int PW = VW + 9;
    localparam int GW = $clog2(OUT_GAP + 1);
    localparam logic [GW-1:0] GAP_LOAD = GW'(OUT_GAP - 1);
    localparam logic signed [PW-1:0] SAT_HI = PW'(127);
    localparam logic signed [PW-1:0] SAT_LO = PW'(-128);

    // Zigzag index -> raster index.
    localparam logic [5:0] ZZ [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    function automatic logic [7:0] dequant(input logic signed [VW-1:0] v, input logic [7:0] q);
        logic signed [PW-1:0] a;
        logic signed [PW-1:0] b;
        logic signed [PW-1:0] p;
        a = PW'(v);
        b = PW'({1'b0, q});
        p = a * b;
        if (p > SAT_HI)      dequant = 8'h7f;
        else if (p < SAT_LO) dequant = 8'h80;
        else                 dequant = p[7:0];
    endfunction

    logic [7:0]        qt  [64];
    logic [7:0]        mem [2][64];
    logic [63:0]       mask [2];
    buf_state_t        state   [2];
    buf_state_t        state_n [2];
    logic [5:0]        k;
    logic              fill_ptr;
    logic              emit_ptr;
    logic [GW-1:0]     gap;

    logic              beat;
    logic [6:0]        pos;
    logic              overrun;
    logic              pure_eob;
    logic              do_write;
    logic              complete;
    logic [5:0]        wr_idx;
    logic [7:0]        wr_byte;
    logic signed [VW-1:0] mult_val;
    logic              dc_fill;
    logic [7:0]        dc_byte;
    logic              emit;
    logic [511:0]      emit_data;

    assign coef_ready = (state[fill_ptr] == BUF_EMPTY) || (state[fill_ptr] == BUF_FILLING);
    assign beat       = coef_valid && coef_ready;
    assign pos        = {1'b0, k} + {1'b0, coef_run};
    assign overrun    = pos[6];
    assign pure_eob   = coef_eob && (coef_run == 6'd0) && (coef_value == '0);
    assign do_write   = beat && !overrun && !pure_eob;
    assign complete   = beat && (coef_eob || overrun || (pos == 7'd63));
    assign wr_idx     = ZZ[pos[5:0]];
    assign wr_byte    = dequant(mult_val, qt[pos[5:0]]);

`ifdef DEZIGZAG_DC_PRED_EN
    logic signed [VW-1:0] dc_pred;
    logic signed [VW-1:0] pred_base;
    logic signed [VW-1:0] dc_sum;
    logic                 dc_beat;

    // A clear coinciding with a DC beat takes effect before the add.
    assign pred_base = dc_pred_clr ? '0 : dc_pred;
    assign dc_sum    = pred_base + VW'($signed(coef_value));
    assign dc_beat   = do_write && (pos == 7'd0);
    assign mult_val  = dc_beat ? dc_sum : VW'($signed(coef_value));
    // A block that skips k==0 still carries the predicted DC (difference 0).
    assign dc_fill   = beat && (k == 6'd0) && !dc_beat;
    assign dc_byte   = dequant(pred_base, qt[0]);

    always_ff @(posedge clk) begin
        if (rst)              dc_pred <= '0;
        else if (dc_beat)     dc_pred <= dc_sum;
        else if (dc_pred_clr) dc_pred <= '0;
    end
`else
    logic unused_dc_pred_clr;

    assign unused_dc_pred_clr = dc_pred_clr;
    assign mult_val           = $signed(coef_value);
    assign dc_fill            = 1'b0;
    assign dc_byte            = 8'h00;
`endif

    // The completing beat may be emitted in the same cycle, so its write is bypassed in.
    assign emit = (gap == '0) &&
                  ((state[emit_ptr] == BUF_FULL) || (complete && (fill_ptr == emit_ptr)));

    always_comb begin
        emit_data = '0;
        for (int i = 0; i < 64; i++) begin
            if (mask[emit_ptr][i])
                emit_data[8*i +: 8] = mem[emit_ptr][i];
            if (do_write && (fill_ptr == emit_ptr) && (wr_idx == 6'(i)))
                emit_data[8*i +: 8] = wr_byte;
        end
        if (dc_fill && (fill_ptr == emit_ptr))
            emit_data[7:0] = dc_byte;
    end

    always_comb begin
        for (int b = 0; b < 2; b++) begin
            // NOTE: every always_comb output is defaulted first so no path can infer a latch.
            state_n[b] = state[b];
            if (state[b] == BUF_EMITTED)
                state_n[b] = BUF_EMPTY;
            if (beat && (fill_ptr == 1'(b)))
                state_n[b] = complete ? BUF_FULL : BUF_FILLING;
            if (emit && (emit_ptr == 1'(b)))
                state_n[b] = BUF_EMITTED;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            for (int b = 0; b < 2; b++) state[b] <= BUF_EMPTY;
        end else begin
            for (int b = 0; b < 2; b++) state[b] <= state_n[b];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            k           <= '0;
            fill_ptr    <= 1'b0;
            emit_ptr    <= 1'b0;
            gap         <= '0;
            blk_valid   <= 1'b0;
            blk_data    <= '0;
            err_overrun <= 1'b0;
            mask[0]     <= '0;
            mask[1]     <= '0;
        end else begin
            if (beat)
                k <= complete ? 6'd0 : pos[5:0] + 6'd1;
            if (complete)
                fill_ptr <= ~fill_ptr;
            if (emit)
                emit_ptr <= ~emit_ptr;
            if (beat && overrun)
                err_overrun <= 1'b1;
            blk_valid <= emit;
            if (emit) begin
                blk_data <= emit_data;
                gap      <= GAP_LOAD;
            end else if (gap != '0) begin
                gap <= gap - GW'(1);
            end
            // The written-mask stands in for a clear pass over the data array.
            for (int b = 0; b < 2; b++)
                if (state[b] == BUF_EMITTED) mask[b] <= '0;
            if (do_write)
                mask[fill_ptr][wr_idx] <= 1'b1;
            if (dc_fill)
                mask[fill_ptr][0] <= 1'b1;
        end
    end

    // NOTE: the coefficient buffers and quant table carry no reset; the written-mask makes stale data invisible.
    always_ff @(posedge clk) begin
        if (qt_wr_en)
            qt[qt_wr_addr] <= qt_wr_data;
        if (do_write)
            mem[fill_ptr][wr_idx] <= wr_byte;
        if (dc_fill)
            mem[fill_ptr][0] <= dc_byte;
    end

endmodule

// File: tb/tb_dezigzag_dequant.sv
// Directed bench for dezigzag_dequant: dequant, zigzag scatter, saturation, buffering, spacing, overrun, reset.
// With DEZIGZAG_DC_PRED_EN defined the predictor is held cleared except during the DC sequence.
module tb_dezigzag_dequant;

    localparam int CW      = 12;
    localparam int OUT_GAP = 40;

    logic          clk = 1'b0;
    logic          rst;
    logic          coef_valid;
    logic          coef_ready;
    logic [5:0]    coef_run;
    logic [CW-1:0] coef_value;
    logic          coef_eob;
    logic          qt_wr_en;
    logic [5:0]    qt_wr_addr;
    logic [7:0]    qt_wr_data;
    logic          dc_pred_clr;
    logic          blk_valid;
    logic [511:0]  blk_data;
    logic          err_overrun;

    dezigzag_dequant #(.OUT_GAP(OUT_GAP), .CW(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .coef_valid (coef_valid),
        .coef_ready (coef_ready),
        .coef_run   (coef_run),
        .coef_value (coef_value),
        .coef_eob   (coef_eob),
        .qt_wr_en   (qt_wr_en),
        .qt_wr_addr (qt_wr_addr),
        .qt_wr_data (qt_wr_data),
        .dc_pred_clr(dc_pred_clr),
        .blk_valid  (blk_valid),
        .blk_data   (blk_data),
        .err_overrun(err_overrun)
    );

    always #5 clk = ~clk;

    int zz [64] = '{
         0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
        12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
        35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
        58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
    };

    int           cyc = 0;
    int           pcyc [$];
    logic [511:0] pdata [$];
    int           vectors = 0;
    int           miscompares = 0;
    bit           saw_stall;
    logic [511:0] last;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (blk_valid) begin
            pcyc.push_back(cyc);
            pdata.push_back(blk_data);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input int run, input int value, input bit eob);
        coef_run   = 6'(run);
        coef_value = CW'(value);
        coef_eob   = eob;
        coef_valid = 1'b1;
        for (int n = 0; !coef_ready && n < 500; n++) begin
            saw_stall = 1'b1;
            step();
        end
        check("beat accepted", 512'(coef_ready), 512'(1));
        step();
        coef_valid = 1'b0;
        coef_eob   = 1'b0;
    endtask

    task automatic wait_pulse(input int target);
        for (int n = 0; pcyc.size() < target && n < 400; n++) step();
        check("pulse count", 512'(pcyc.size()), 512'(target));
    endtask

    task automatic qt_write(input int addr, input int data);
        qt_wr_en   = 1'b1;
        qt_wr_addr = 6'(addr);
        qt_wr_data = 8'(data);
        step();
        qt_wr_en = 1'b0;
    endtask

    function automatic logic [511:0] last_blk();
        if (pdata.size() == 0) return '0;
        return pdata[pdata.size()-1];
    endfunction

    function automatic logic [511:0] zz_block(input int n);
        logic [511:0] r;
        r = '0;
        for (int j = 0; j < n; j++) r[8*zz[j] +: 8] = 8'(j + 1);
        return r;
    endfunction

    initial begin
        rst        = 1'b1;
        coef_valid = 1'b0;
        coef_run   = '0;
        coef_value = '0;
        coef_eob   = 1'b0;
        qt_wr_en   = 1'b0;
        qt_wr_addr = '0;
        qt_wr_data = '0;
        saw_stall  = 1'b0;
`ifdef DEZIGZAG_DC_PRED_EN
        dc_pred_clr = 1'b1;
`else
        dc_pred_clr = 1'b0;
`endif
        step();
        step();
        check("reset coef_ready", 512'(coef_ready), 512'(1));
        check("reset blk_valid", 512'(blk_valid), 512'(0));
        check("reset blk_data", blk_data, '0);
        check("reset err_overrun", 512'(err_overrun), 512'(0));
        rst = 1'b0;

        for (int i = 0; i < 64; i++) qt_write(i, 1);

        // DC value then a pure EOB; pulse lands the cycle after the completing beat.
        send(0, 5, 1'b0);
        send(0, 0, 1'b1);
        check("eob latency", 512'(blk_valid), 512'(1));
        wait_pulse(1);
        check("dc 5", last_blk(), 512'h05);
        check("no overrun", 512'(err_overrun), 512'(0));
        for (int i = 0; i < 5; i++) step();
        check("single pulse", 512'(pcyc.size()), 512'(1));

        qt_write(1, 2);
        send(1, -3, 1'b1);
        wait_pulse(2);
        check("k1 -3*2", last_blk(), 512'hFA00);

        qt_write(0, 16);
        send(0, 100, 1'b1);
        wait_pulse(3);
        check("sat high", last_blk(), 512'h7F);
        send(0, -100, 1'b1);
        wait_pulse(4);
        check("sat low", last_blk(), 512'h80);
        qt_write(0, 1);
        qt_write(1, 1);

        // Full 64-beat block closes at k==63 without EOB.
        for (int j = 1; j <= 64; j++) send(0, j, 1'b0);
        wait_pulse(5);
        last = last_blk();
        check("full block", last, zz_block(64));
        check("r7c7", 512'(last[511:504]), 512'(64));
        check("r1c0", 512'(last[71:64]), 512'(3));
        send(0, 9, 1'b1);
        wait_pulse(6);
        check("k restarts", last_blk(), 512'h09);

        // Three blocks while the gap runs: second fill leaves both buffers full.
        saw_stall = 1'b0;
        send(0, 11, 1'b1);
        send(0, 22, 1'b1);
        check("ready low both full", 512'(coef_ready), 512'(0));
        send(0, 33, 1'b1);
        check("stall seen", 512'(saw_stall), 512'(1));
        wait_pulse(9);
        check("blk A", pdata[6], 512'h0B);
        check("blk B", pdata[7], 512'h16);
        check("blk C", pdata[8], 512'h21);
        check("gap A", 512'(pcyc[6] - pcyc[5]), 512'(OUT_GAP));
        check("gap B", 512'(pcyc[7] - pcyc[6]), 512'(OUT_GAP));
        check("gap C", 512'(pcyc[8] - pcyc[7]), 512'(OUT_GAP));

        // Overrun at k=10 drops the value and closes the block.
        for (int j = 1; j <= 10; j++) send(0, j, 1'b0);
        send(60, 77, 1'b0);
        wait_pulse(10);
        check("overrun block", last_blk(), zz_block(10));
        check("overrun flag", 512'(err_overrun), 512'(1));

        // Reset with one full buffer waiting and one partly filled.
        send(0, 50, 1'b1);
        send(0, 51, 1'b0);
        send(0, 52, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst err_overrun", 512'(err_overrun), 512'(0));
        check("rst blk_valid", 512'(blk_valid), 512'(0));
        check("rst blk_data", blk_data, '0);
        check("rst coef_ready", 512'(coef_ready), 512'(1));
        for (int i = 0; i < 60; i++) step();
        check("no pulse after rst", 512'(pcyc.size()), 512'(10));

        send(0, 3, 1'b1);
        wait_pulse(11);
        check("qt kept over rst", last_blk(), 512'h03);

        // Table write in the same cycle as a beat: old entry applies to that beat.
        step();
        step();
        qt_wr_en   = 1'b1;
        qt_wr_addr = 6'd0;
        qt_wr_data = 8'd2;
        send(0, 4, 1'b1);
        qt_wr_en = 1'b0;
        wait_pulse(12);
        check("qt old entry", last_blk(), 512'h04);
        send(0, 4, 1'b1);
        wait_pulse(13);
        check("qt new entry", last_blk(), 512'h08);

`ifdef DEZIGZAG_DC_PRED_EN
        qt_write(0, 1);
        dc_pred_clr = 1'b0;
        send(0, 10, 1'b1);
        wait_pulse(14);
        check("dc pred 10", last_blk(), 512'h0A);
        send(0, 5, 1'b1);
        wait_pulse(15);
        check("dc pred 15", last_blk(), 512'h0F);
        dc_pred_clr = 1'b1;
        step();
        dc_pred_clr = 1'b0;
        send(0, 7, 1'b1);
        wait_pulse(16);
        check("dc pred clr 7", last_blk(), 512'h07);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
